regfile_wb_scheduler: RTL and testbench

//  Shares the register file's single write port between two writeback sources
//  (ALU, load/store unit) using round-robin arbitration. Keeps a per-register

---
 rtl/regfile_wb_scheduler.sv | 111 +++++++++++
 tb/tb_regfile_wb_scheduler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// Round-robin arbiter sharing the register-file write port between ALU and LSU
// writebacks, plus a per-register busy scoreboard for issue-stage hazard checks.
module regfile_wb_scheduler #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_rd,
  output logic              mark_ok,
  input  logic [ADDR_W-1:0] chk_a,
  input  logic [ADDR_W-1:0] chk_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic              err_waw
);

  typedef enum logic {SRC_ALU = 1'b0, SRC_LSU = 1'b1} src_e;

  src_e                last_grant_q, last_grant_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                err_waw_q, err_waw_d;

  // On a tie the source that did not win last time is served.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (!flush) begin
      alu_ready = alu_valid && (!lsu_valid || (last_grant_q == SRC_LSU));
      lsu_ready = lsu_valid && (!alu_valid || (last_grant_q == SRC_ALU));
    end
  end

  assign mark_ok = (mark_rd == '0) || !busy_q[mark_rd];
  assign busy_a  = (chk_a != '0) && busy_q[chk_a];
  assign busy_b  = (chk_b != '0) && busy_q[chk_b];

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign err_waw = err_waw_q;

  always_comb begin
    last_grant_d = last_grant_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    busy_d       = busy_q;
    err_waw_d    = err_waw_q;

    if (alu_ready) begin
      last_grant_d = SRC_ALU;
      wr_en_d      = (alu_rd != '0);
      wr_addr_d    = alu_rd;
      wr_data_d    = alu_data;
    end else if (lsu_ready) begin
      last_grant_d = SRC_LSU;
      wr_en_d      = (lsu_rd != '0);
      wr_addr_d    = lsu_rd;
      wr_data_d    = lsu_data;
    end

    // Clear on commit first so a same-edge claim of that register wins.
    if (wr_en_q) busy_d[wr_addr_q] = 1'b0;
    if (mark_en && mark_ok && (mark_rd != '0)) busy_d[mark_rd] = 1'b1;
    if (mark_en && !mark_ok) err_waw_d = 1'b1;

    if (flush) begin
      last_grant_d = SRC_LSU;
      busy_d       = '0;
      err_waw_d    = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= SRC_LSU;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= '0;
      err_waw_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      err_waw_q    <= err_waw_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed testbench for regfile_wb_scheduler: arbitration, write latency,
// scoreboard set/clear, WAW error, rd==0 handling, flush and async reset.
module tb_regfile_wb_scheduler;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n, flush;
  logic              alu_valid, lsu_valid, alu_ready, lsu_ready;
  logic [ADDR_W-1:0] alu_rd, lsu_rd, wr_addr, mark_rd, chk_a, chk_b;
  logic [DATA_W-1:0] alu_data, lsu_data, wr_data;
  logic              wr_en, mark_en, mark_ok, busy_a, busy_b, err_waw;

  int tests = 0;
  int fails = 0;

  regfile_wb_scheduler #(.NUM_REGS(32), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mark_en(mark_en), .mark_rd(mark_rd), .mark_ok(mark_ok),
    .chk_a(chk_a), .chk_b(chk_b), .busy_a(busy_a), .busy_b(busy_b),
    .err_waw(err_waw)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; alu_valid = 0; lsu_valid = 0; mark_en = 0;
    alu_rd = 0; lsu_rd = 0; alu_data = 0; lsu_data = 0;
    mark_rd = 0; chk_a = 0; chk_b = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    chk_a = 5; chk_b = 31; mark_rd = 5;
    #3;
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    tests++; if (wr_addr !== 5'd0) begin fails++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
    tests++; if (wr_data !== 32'd0) begin fails++; $display("FAIL reset_wr_data got=%h exp=0", wr_data); end
    tests++; if (err_waw !== 1'b0) begin fails++; $display("FAIL reset_err_waw got=%b exp=0", err_waw); end
    tests++; if ({busy_a, busy_b, mark_ok} !== 3'b001) begin fails++; $display("FAIL reset_busy got=%b exp=001", {busy_a, busy_b, mark_ok}); end
    tick();
    rst_n = 1;
    #1;
  endtask

  task automatic test_single_write();
    apply_reset();
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    #1;
    tests++; if ({alu_ready, lsu_ready} !== 2'b10) begin fails++; $display("FAIL single_ready got=%b exp=10", {alu_ready, lsu_ready}); end
    tick();
    alu_valid = 0;
    tests++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      fails++; $display("FAIL single_write got en=%b addr=%0d data=%h exp en=1 addr=5 data=deadbeef", wr_en, wr_addr, wr_data);
    end
    tick();
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL single_write_drop got=%b exp=0", wr_en); end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] alu_seq [4] = '{5'd1, 5'd3, 5'd3, 5'd5};
    logic [ADDR_W-1:0] lsu_seq [4] = '{5'd2, 5'd2, 5'd4, 5'd4};
    logic [1:0]        exp_rdy [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    logic [ADDR_W-1:0] exp_addr [4] = '{5'd1, 5'd2, 5'd3, 5'd4};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_rd = alu_seq[i]; alu_data = 32'hA000_0000 | 32'(alu_seq[i]);
      lsu_valid = 1; lsu_rd = lsu_seq[i]; lsu_data = 32'hB000_0000 | 32'(lsu_seq[i]);
      #1;
      tests++; if ({alu_ready, lsu_ready} !== exp_rdy[i]) begin
        fails++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, {alu_ready, lsu_ready}, exp_rdy[i]);
      end
      tick();
      tests++; if ({wr_en, wr_addr} !== {1'b1, exp_addr[i]} ||
                   wr_data !== ((exp_rdy[i][1] ? 32'hA000_0000 : 32'hB000_0000) | 32'(exp_addr[i]))) begin
        fails++; $display("FAIL rr_write[%0d] got en=%b addr=%0d data=%h exp addr=%0d", i, wr_en, wr_addr, wr_data, exp_addr[i]);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_scoreboard();
    apply_reset();
    mark_en = 1; mark_rd = 7; chk_a = 7;
    #1;
    tests++; if (mark_ok !== 1'b1) begin fails++; $display("FAIL sb_mark_ok got=%b exp=1", mark_ok); end
    tick();
    mark_en = 0;
    tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL sb_busy_set got=%b exp=1", busy_a); end
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h1234_5678;
    #1;
    tests++; if ({alu_ready, lsu_ready} !== 2'b01) begin fails++; $display("FAIL sb_lsu_ready got=%b exp=01", {alu_ready, lsu_ready}); end
    tick();
    lsu_valid = 0;
    tests++; if ({wr_en, wr_addr, busy_a} !== {1'b1, 5'd7, 1'b1}) begin
      fails++; $display("FAIL sb_wr_cycle got en=%b addr=%0d busy=%b exp en=1 addr=7 busy=1", wr_en, wr_addr, busy_a);
    end
    tick();
    tests++; if ({wr_en, busy_a} !== 2'b00) begin fails++; $display("FAIL sb_busy_clear got=%b exp=00", {wr_en, busy_a}); end
  endtask

  task automatic test_waw();
    apply_reset();
    mark_en = 1; mark_rd = 9; chk_a = 9;
    tick();
    #1;
    tests++; if (mark_ok !== 1'b0) begin fails++; $display("FAIL waw_mark_ok got=%b exp=0", mark_ok); end
    tick();
    mark_en = 0;
    tests++; if ({err_waw, busy_a} !== 2'b11) begin fails++; $display("FAIL waw_err got=%b exp=11", {err_waw, busy_a}); end
    alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
    tick();
    alu_valid = 0;
    tick();
    tests++; if ({err_waw, busy_a} !== 2'b10) begin fails++; $display("FAIL waw_after_write got=%b exp=10", {err_waw, busy_a}); end
  endtask

  task automatic test_rd_zero();
    apply_reset();
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF_FFFF;
    #1;
    tests++; if (alu_ready !== 1'b1) begin fails++; $display("FAIL r0_ready got=%b exp=1", alu_ready); end
    tick();
    alu_valid = 0;
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL r0_wr_en got=%b exp=0", wr_en); end
    mark_en = 1; mark_rd = 0; chk_a = 0;
    #1;
    tests++; if (mark_ok !== 1'b1) begin fails++; $display("FAIL r0_mark_ok got=%b exp=1", mark_ok); end
    tick();
    mark_en = 0;
    tests++; if ({busy_a, err_waw} !== 2'b00) begin fails++; $display("FAIL r0_busy got=%b exp=00", {busy_a, err_waw}); end
  endtask

  task automatic test_flush();
    apply_reset();
    mark_en = 1; mark_rd = 3;
    tick();
    mark_rd = 4;
    tick();
    mark_rd = 3;
    tick();
    mark_en = 0; chk_a = 3; chk_b = 4;
    #1;
    tests++; if ({busy_a, busy_b, err_waw} !== 3'b111) begin fails++; $display("FAIL fl_pre got=%b exp=111", {busy_a, busy_b, err_waw}); end
    alu_valid = 1; alu_rd = 10; alu_data = 32'h0A0A_0A0A;
    tick();
    flush = 1; lsu_valid = 1; lsu_rd = 11; lsu_data = 32'h0B;
    mark_en = 1; mark_rd = 12;
    #1;
    tests++; if ({alu_ready, lsu_ready} !== 2'b00) begin fails++; $display("FAIL fl_ready got=%b exp=00", {alu_ready, lsu_ready}); end
    tests++; if ({wr_en, wr_addr} !== {1'b1, 5'd10}) begin fails++; $display("FAIL fl_inflight got en=%b addr=%0d exp en=1 addr=10", wr_en, wr_addr); end
    tick();
    flush = 0; mark_en = 0;
    tests++; if ({wr_en, busy_a, busy_b, err_waw} !== 4'b0000) begin
      fail_line("fl_after", {wr_en, busy_a, busy_b, err_waw});
    end
    chk_a = 12;
    #1;
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL fl_mark_dropped got=%b exp=0", busy_a); end
    tests++; if ({alu_ready, lsu_ready} !== 2'b10) begin fails++; $display("FAIL fl_tie got=%b exp=10", {alu_ready, lsu_ready}); end
    idle_inputs();
    tick();
  endtask

  task automatic fail_line(input string name, input logic [3:0] got);
    fails++;
    $display("FAIL %s got=%b exp=0000", name, got);
  endtask

  task automatic test_reset_midop();
    apply_reset();
    alu_valid = 1; alu_rd = 6; alu_data = 32'h66;
    mark_en = 1; mark_rd = 8; chk_a = 8;
    tick();
    idle_inputs();
    chk_a = 8;
    rst_n = 0;
    #1;
    tests++; if ({wr_en, wr_addr, wr_data, busy_a} !== {1'b0, 5'd0, 32'd0, 1'b0}) begin
      fails++; $display("FAIL midop_reset got en=%b addr=%0d data=%h busy=%b exp all 0", wr_en, wr_addr, wr_data, busy_a);
    end
    tick();
    rst_n = 1;
    #1;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_scoreboard();
    test_waw();
    test_rd_zero();
    test_flush();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
